// File: rtl/ddr_ready_monitor_pkg.sv
// Shared definitions for the DDR ready monitor: state encoding and default limits.
// ITERATION_COUNT default matches the upstream init/reset iterator's retry limit.
package ddr_ready_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_READY = 3'd1,
    ST_QUALIFY    = 3'd2,
    ST_RUN        = 3'd3,
    ST_FAIL       = 3'd4,
    ST_LOST       = 3'd5
  } ddr_mon_state_e;

  localparam logic [3:0]  DDR_ITERATION_COUNT = 4'hA;
  localparam logic [15:0] DDR_QUALIFY_CYCLES  = 16'd256;

  // States in which the time-to-ready measurement is still running
  function automatic logic is_pre_run(input ddr_mon_state_e s);
    return (s == ST_IDLE) || (s == ST_WAIT_READY) || (s == ST_QUALIFY);
  endfunction

endpackage

// File: rtl/ddr_sat_counter.sv
// Saturating up-counter with synchronous clear (priority over enable).
module ddr_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/ddr_ready_monitor.sv
// Qualifies DDR controller ready after iterator release, gates the fabric reset,
// and reports training failure / ready loss with attempt count and time-to-ready.
module ddr_ready_monitor
  import ddr_ready_monitor_pkg::*;
#(
  parameter logic [15:0] QUALIFY_CYCLES  = DDR_QUALIFY_CYCLES,
  parameter logic [3:0]  ITERATION_COUNT = DDR_ITERATION_COUNT,
  parameter int          LAT_W           = 24
) (
  input  logic             clk,
  input  logic             SYS_RESET_IN,
  input  logic             ddr_reset_n,
  input  logic             ctrlr_ready,
  input  logic [3:0]       reset_counter,
  input  logic             clear_error,
  output logic             FABRIC_RESET_N,
  output logic             ddr_ready,
  output logic             training_fail,
  output logic             ready_lost,
  output logic [3:0]       attempts,
  output logic [LAT_W-1:0] ready_latency
);

  ddr_mon_state_e state_reg, state_next;
  logic [15:0]    qcnt_reg, qcnt_next;
  logic           fabric_reset_n_reg, ddr_ready_reg, training_fail_reg, ready_lost_reg;
  logic [3:0]     attempts_reg;
  logic           clear_evt;
  logic           enter_done;

  assign clear_evt  = clear_error && ((state_reg == ST_FAIL) || (state_reg == ST_LOST));
  assign enter_done = ((state_next == ST_RUN)  && (state_reg != ST_RUN)) ||
                      ((state_next == ST_FAIL) && (state_reg != ST_FAIL));

  always_comb begin
    state_next = state_reg;
    qcnt_next  = qcnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (ddr_reset_n) state_next = ST_WAIT_READY;
      end
      ST_WAIT_READY: begin
        if (!ddr_reset_n) begin
          state_next = ST_IDLE;
        end else if (ctrlr_ready) begin
          state_next = ST_QUALIFY;
          qcnt_next  = 16'd1;
        end else if (reset_counter == ITERATION_COUNT) begin
          state_next = ST_FAIL;
        end
      end
      ST_QUALIFY: begin
        if (!ddr_reset_n) begin
          state_next = ST_IDLE;
          qcnt_next  = '0;
        end else if (!ctrlr_ready) begin
          state_next = ST_WAIT_READY;
          qcnt_next  = '0;
        end else if (qcnt_reg == QUALIFY_CYCLES) begin
          state_next = ST_RUN;
        end else begin
          qcnt_next = qcnt_reg + 16'd1;
        end
      end
      ST_RUN: begin
        if (!ctrlr_ready || !ddr_reset_n) state_next = ST_LOST;
      end
      ST_FAIL, ST_LOST: begin
        if (clear_error) begin
          state_next = ST_IDLE;
          qcnt_next  = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        qcnt_next  = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the transition edge
  always_ff @(posedge clk or posedge SYS_RESET_IN) begin
    if (SYS_RESET_IN) begin
      state_reg          <= ST_IDLE;
      qcnt_reg           <= '0;
      fabric_reset_n_reg <= 1'b0;
      ddr_ready_reg      <= 1'b0;
      training_fail_reg  <= 1'b0;
      ready_lost_reg     <= 1'b0;
      attempts_reg       <= '0;
    end else begin
      state_reg          <= state_next;
      qcnt_reg           <= qcnt_next;
      fabric_reset_n_reg <= (state_next == ST_RUN);
      ddr_ready_reg      <= (state_next == ST_RUN);
      training_fail_reg  <= (state_next == ST_FAIL);
      ready_lost_reg     <= (state_next == ST_LOST);
      if (enter_done) begin
        attempts_reg <= reset_counter;
      end else if (clear_evt) begin
        attempts_reg <= '0;
      end
    end
  end

  ddr_sat_counter #(.W(LAT_W)) u_latency (
    .clk   (clk),
    .rst   (SYS_RESET_IN),
    .en    (is_pre_run(state_reg)),
    .clr   (clear_evt),
    .count (ready_latency)
  );

  assign FABRIC_RESET_N = fabric_reset_n_reg;
  assign ddr_ready      = ddr_ready_reg;
  assign training_fail  = training_fail_reg;
  assign ready_lost     = ready_lost_reg;
  assign attempts       = attempts_reg;

endmodule

// File: tb/tb_ddr_ready_monitor.sv
// Directed bench for ddr_ready_monitor: a behavioural model tracked per edge, a per-cycle
// compare process, and hand-computed literal checks at the interesting points.
module tb_ddr_ready_monitor;

  localparam int Q    = 4;
  localparam int ITER = 3;
  localparam int LATW = 8;
  localparam int LMAX = (1 << LATW) - 1;

  logic            clk;
  logic            sys_rst;
  logic            ddr_n;
  logic            ready;
  logic [3:0]      rc;
  logic            clr;
  logic            fab_n;
  logic            ddr_rdy;
  logic            t_fail;
  logic            r_lost;
  logic [3:0]      att;
  logic [LATW-1:0] lat;

  int checks = 0;
  int fails  = 0;

  ddr_ready_monitor #(
    .QUALIFY_CYCLES  (16'(Q)),
    .ITERATION_COUNT (4'(ITER)),
    .LAT_W           (LATW)
  ) dut (
    .clk            (clk),
    .SYS_RESET_IN   (sys_rst),
    .ddr_reset_n    (ddr_n),
    .ctrlr_ready    (ready),
    .reset_counter  (rc),
    .clear_error    (clr),
    .FABRIC_RESET_N (fab_n),
    .ddr_ready      (ddr_rdy),
    .training_fail  (t_fail),
    .ready_lost     (r_lost),
    .attempts       (att),
    .ready_latency  (lat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: "released" = DDR seen out of reset, "streak" = consecutive ready
  // edges since release; RUN once the streak exceeds Q.
  bit       m_released, m_running, m_failed, m_lost;
  int       m_streak;
  int       m_lat;
  int       m_attempts;

  task automatic model_clear();
    m_released = 0; m_running = 0; m_failed = 0; m_lost = 0;
    m_streak = 0; m_lat = 0; m_attempts = 0;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge sys_rst);
      if (sys_rst) begin
        model_clear();
      end else if (m_failed || m_lost) begin
        if (clr) model_clear();
      end else if (m_running) begin
        if (!ready || !ddr_n) begin
          m_running = 0;
          m_lost    = 1;
        end
      end else begin
        m_lat = (m_lat < LMAX) ? m_lat + 1 : LMAX;
        if (!m_released) begin
          if (ddr_n) m_released = 1;
        end else if (!ddr_n) begin
          m_released = 0;
          m_streak   = 0;
        end else if (ready) begin
          m_streak++;
          if (m_streak == Q + 1) begin
            m_running  = 1;
            m_attempts = int'(rc);
          end
        end else if (m_streak > 0) begin
          m_streak = 0;
        end else if (int'(rc) == ITER) begin
          m_failed   = 1;
          m_attempts = int'(rc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(name, act, exp);
    $display("pin %-20s actual=%0d required=%0d t=%0t", name, act, exp, $time);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check("cyc_fabric_reset_n", 32'(fab_n),   32'(m_running));
      check("cyc_ddr_ready",      32'(ddr_rdy), 32'(m_running));
      check("cyc_training_fail",  32'(t_fail),  32'(m_failed));
      check("cyc_ready_lost",     32'(r_lost),  32'(m_lost));
      check("cyc_attempts",       32'(att),     32'(m_attempts));
      check("cyc_ready_latency",  32'(lat),     32'(m_lat));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Enters with reset asserted; edge numbering starts at the first edge after release
  task automatic seq1(input string tag);
    ddr_n = 1'b0; ready = 1'b0; rc = 4'd2; clr = 1'b0;
    sys_rst = 1'b0;
    step(1);
    ddr_n = 1'b1;
    step(8);
    ready = 1'b1;
    step(4);
    pin({tag, "_fab_e13"}, 32'(fab_n), 32'd0);
    step(1);
    pin({tag, "_fab_e14"},  32'(fab_n),   32'd1);
    pin({tag, "_rdy_e14"},  32'(ddr_rdy), 32'd1);
    pin({tag, "_att_e14"},  32'(att),     32'd2);
    pin({tag, "_lat_e14"},  32'(lat),     32'd14);
    step(5);
    pin({tag, "_lat_frozen"}, 32'(lat), 32'd14);
  endtask

  initial begin
    sys_rst = 1'b1; ddr_n = 1'b0; ready = 1'b0; rc = 4'd0; clr = 1'b0;
    step(3);
    pin("reset_fab", 32'(fab_n), 32'd0);
    pin("reset_lat", 32'(lat),   32'd0);

    seq1("t1");

    // Loss of ready in RUN, sticky until cleared
    ready = 1'b0;
    step(1);
    pin("t4_lost",     32'(r_lost),  32'd1);
    pin("t4_fab",      32'(fab_n),   32'd0);
    pin("t4_rdy",      32'(ddr_rdy), 32'd0);
    ready = 1'b1;
    step(3);
    pin("t4_lost_hold", 32'(r_lost), 32'd1);
    pin("t4_fab_hold",  32'(fab_n),  32'd0);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    pin("t4_clr_lost", 32'(r_lost), 32'd0);
    pin("t4_clr_att",  32'(att),    32'd0);
    pin("t4_clr_lat",  32'(lat),    32'd0);

    // Qualification restart after a one-cycle dropout
    ready = 1'b0;
    step(1);
    ready = 1'b1;
    step(3);
    ready = 1'b0;
    step(1);
    pin("t2_no_early", 32'(fab_n), 32'd0);
    ready = 1'b1;
    step(4);
    pin("t2_fab_b3", 32'(fab_n), 32'd0);
    step(1);
    pin("t2_fab_b4", 32'(fab_n), 32'd1);

    // Iterations exhausted while never ready
    ready = 1'b0;
    step(1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    rc = 4'd0; step(1);
    rc = 4'd1; step(1);
    rc = 4'd2; step(1);
    pin("t3_fail_rc2", 32'(t_fail), 32'd0);
    rc = 4'd3; step(1);
    pin("t3_fail",     32'(t_fail), 32'd1);
    pin("t3_att",      32'(att),    32'd3);
    pin("t3_fab",      32'(fab_n),  32'd0);
    ready = 1'b1;
    step(3);
    pin("t3_late_fail", 32'(t_fail), 32'd1);
    pin("t3_late_fab",  32'(fab_n),  32'd0);

    // Latency saturation while held in WAIT_READY
    clr = 1'b1; ready = 1'b0; rc = 4'd0;
    step(1);
    clr = 1'b0;
    pin("t5_clr_fail", 32'(t_fail), 32'd0);
    pin("t5_clr_lat",  32'(lat),    32'd0);
    step(300);
    pin("t5_lat_sat", 32'(lat),   32'd255);
    pin("t5_fab",     32'(fab_n), 32'd0);

    // Asynchronous reset mid-qualification and in RUN
    ready = 1'b1;
    step(2);
    #1 sys_rst = 1'b1;
    #1;
    pin("t6q_lat", 32'(lat),   32'd0);
    pin("t6q_fab", 32'(fab_n), 32'd0);
    step(1);
    seq1("t6a");
    #1 sys_rst = 1'b1;
    #1;
    pin("t6r_fab", 32'(fab_n),   32'd0);
    pin("t6r_rdy", 32'(ddr_rdy), 32'd0);
    pin("t6r_att", 32'(att),     32'd0);
    pin("t6r_lat", 32'(lat),     32'd0);
    step(1);
    seq1("t6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
